serial_ripple_subtractor: RTL
=============================

# serial_ripple_subtractor

Bit-serial subtractor computing `d = a - b - bi` with borrow-out `bo`, one bit per clock. It is built around a single full-subtractor cell that is iterated LSB first, rather than a parallel chain of cells. It is the area-lean inverse-operation counterpart of the parallel ripple-carry adder in the arithmetic examples hierarchy. Operands enter and results leave through valid/ready handshakes, so the block can sit between streaming stages.

## Interface

- `DATA_WIDTH`, default 4: operand/result width in bits; legal range ≥ 1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_vld`  in  1: operand set valid.
- `in_rd`  out  1: block ready to accept operands.
- `a`  in  DATA_WIDTH: minuend.
- `b`  in  DATA_WIDTH: subtrahend.
- `bi`  in  1: borrow-in.
- `out_vld`  out  1: result valid.
- `out_rd`  in  1: downstream ready for the result.
- `d`  out  DATA_WIDTH: difference, modulo 2^DATA_WIDTH.
- `bo`  out  1: borrow-out; 1 iff `a < b + bi` as unsigned values.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- In IDLE, `in_rd` = 1. Any other state gives `in_rd` = 0.
- In DONE, `out_vld` = 1. Any other state gives `out_vld` = 0.
- IDLE → RUN on `in_vld & in_rd`. On that edge:
  - latch `a` and `b` into shift registers `a_sh` and `b_sh`;
  - load the borrow register with `bi`;
  - clear the bit counter to 0.
- RUN, each cycle:
  - full-subtractor on `a_sh[0]`, `b_sh[0]` and borrow;
  - `diff = a ^ b ^ br`;
  - `br_next = (~a & b) | (~(a ^ b) & br)`.
- RUN, each edge:
  - `a_sh` and `b_sh` shift right by 1;
  - `diff` is shifted into the MSB of the result register;
  - the borrow register takes `br_next`;
  - the counter increments.
- RUN → DONE on the edge where counter == DATA_WIDTH-1. That edge processes the final (MSB) bit.
- In DONE, `d` = result register and `bo` = borrow register. Both are held stable while `out_vld` = 1.
- DONE → IDLE on `out_rd`. The next operand set cannot be accepted in the same cycle, because `in_rd` = 0 in DONE.
- `in_vld` is ignored outside IDLE. Operand inputs are sampled only on the accepting edge and may change freely afterwards.
- Counter width is max(1, ceil(log2(DATA_WIDTH))).
- DATA_WIDTH = 1: exactly one RUN cycle.

## Timing

- Reset values while `rst_n` = 0:
  - `in_rd` = 1, `out_vld` = 0, `d` = 0, `bo` = 0;
  - shift registers, counter and borrow register = 0.
- Reset assertion mid-RUN or mid-DONE:
  - the operation is abandoned immediately, asynchronously;
  - no result is ever presented for it;
  - after deassertion the block is in IDLE.
- Latency, with the operands accepted at edge E:
  - `out_vld` rises after edge E+DATA_WIDTH;
  - the result is first consumable at edge E+DATA_WIDTH+1.
- Throughput with `out_rd` tied high: one operation per DATA_WIDTH+2 cycles (accept, DATA_WIDTH RUN edges, one DONE cycle).
- Backpressure:
  - `out_rd` low holds DONE indefinitely;
  - `d`, `bo` and `out_vld` are unchanged for the whole stall.
- Outputs `d` and `bo` are driven from registers, not combinationally from inputs.
- `in_rd` and `out_vld` decode the state register only.

## Structure

- Shared arithmetic-examples package holds the state enum `sub_state_t` {IDLE, RUN, DONE}.
- Sub-module `full_subtractor` (ports `a`, `b`, `bi`, `d`, `bo`), purely combinational. It is instantiated once and is the only arithmetic in the block.
- The top level contains the FSM, the shift registers, the counter and the borrow register.

## Test plan

- DATA_WIDTH=4: a=5, b=3, bi=0 → d=2, bo=0; `out_vld` rises exactly 4 edges after acceptance.
- a=3, b=5, bi=0 → d=0xE, bo=1.
- a=0, b=0, bi=1 → d=0xF, bo=1.
- a=15, b=15, bi=0 → d=0, bo=0.
- Backpressure: hold `out_rd`=0 for 10 cycles in DONE while toggling `in_vld` and the operands:
  - `d` and `bo` stay stable, `in_rd` stays 0, nothing is accepted;
  - then `out_rd`=1 → IDLE and `in_rd`=1 on the next cycle.
- Reset mid-RUN (after 2 bit edges): `out_vld` stays 0 and `in_rd`=1 after reset.
  - The next op a=9, b=4 → d=5, bo=0.
- Random (1000 ops, DATA_WIDTH=4 and 8, random stalls on both handshakes): results match `{bo, d} = a - b - bi` computed at DATA_WIDTH+1 bits.

Source files
------------

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
package serial_ripple_subtractor_pkg;

  // Control states of the serial subtractor
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  // Bit-counter width: max(1, ceil(log2(width)))
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bi, bo set on borrow.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: iterates one full-subtractor cell LSB first,
// with valid/ready handshakes on operand and result sides.
module serial_ripple_subtractor
  import serial_ripple_subtractor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rd,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  bi,
  output logic                  out_vld,
  input  logic                  out_rd,
  output logic [DATA_WIDTH-1:0] d,
  output logic                  bo
);

  localparam int unsigned     CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  sub_state_t            state;
  sub_state_t            state_nxt;
  logic [DATA_WIDTH-1:0] a_sh;
  logic [DATA_WIDTH-1:0] b_sh;
  logic [DATA_WIDTH-1:0] res;
  logic [DATA_WIDTH-1:0] res_shift;
  logic [CNT_W-1:0]      cnt;
  logic                  br;
  logic                  diff;
  logic                  br_nxt;
  logic                  accept;
  logic                  last_bit;

  // The only arithmetic: one cell on the current LSBs and borrow
  full_subtractor u_fs (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .bi (br),
    .d  (diff),
    .bo (br_nxt)
  );

  assign in_rd    = (state == IDLE);
  assign out_vld  = (state == DONE);
  assign accept   = in_vld & in_rd;
  assign last_bit = (cnt == CNT_LAST);
  assign d        = res;
  assign bo       = br;

  // New difference bit enters at the MSB of the result register
  if (DATA_WIDTH == 1) begin : g_res_one
    assign res_shift = diff;
  end else begin : g_res_many
    assign res_shift = {diff, res[DATA_WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (out_rd)   state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Operand capture and one-bit-per-edge datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bi;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      res  <= res_shift;
      br   <= br_nxt;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule
